prot_eng_rx: RTL and testbench

- Receive-side protocol engine: parses Ethernet/IPv4/UDP frames arriving as 36-bit FIFO words (eth padded to 16 bytes, 11 header words).
- Validates headers against programmed local MAC/IP and an 8-entry UDP port table.
- Strips headers and emits one control word {port index, payload length} followed by the payload; non-matching or truncated frames are dropped and counted.
- Sits between the MAC receive FIFO and the per-port stream demux.

---
 rtl/prot_eng_rx.sv | 268 ++++++++++++++++++++++++++
 tb/tb_prot_eng_rx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prot_eng_rx.sv
// Receive-side Ethernet/IPv4/UDP filter: parses 11 header words, checks MAC/IP/UDP port,
// re-emits matching frames as {port index, payload length} control word followed by payload.
module prot_eng_rx #(
  parameter int BASE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [35:0] datain,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [35:0] dataout,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

  typedef enum logic [2:0] {IDLE, HDR, CTRL, PAY, DROP} state_t;

  localparam logic [7:0] A_MAC_HI = 8'(BASE);
  localparam logic [7:0] A_MAC_LO = 8'(BASE + 1);
  localparam logic [7:0] A_IP     = 8'(BASE + 2);

  logic [35:0] in_data, core_data;
  logic        in_valid, in_ready, core_valid, out_ready;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [15:0] ethertype_q, ethertype_d;
  logic [7:0]  protocol_q, protocol_d;
  logic [31:0] dst_ip_q, dst_ip_d;
  logic [15:0] dst_port_q, dst_port_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic        ctrl_eof_q, ctrl_eof_d;
  logic [2:0]  port_k_q, port_k_d;
  logic [47:0] my_mac_q, my_mac_d;
  logic [31:0] my_ip_q, my_ip_d;
  logic [7:0]  port_valid_q, port_valid_d;
  logic [15:0] port_num_q [8];
  logic [15:0] port_num_d [8];
  logic [15:0] frames_ok_q, frames_ok_d;
  logic [15:0] frames_dropped_q, frames_dropped_d;
  logic [7:0]  port_wr;
  logic        hit;
  logic [2:0]  hit_k;
  logic        frame_match;

  fifo_short u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .datain    (datain),
    .src_rdy_i (src_rdy_i),
    .dst_rdy_o (dst_rdy_o),
    .dataout   (in_data),
    .src_rdy_o (in_valid),
    .dst_rdy_i (in_ready)
  );

  fifo_short u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .datain    (core_data),
    .src_rdy_i (core_valid),
    .dst_rdy_o (out_ready),
    .dataout   (dataout),
    .src_rdy_o (src_rdy_o),
    .dst_rdy_i (dst_rdy_i)
  );

  for (genvar gi = 0; gi < 8; gi++) begin : g_port_dec
    assign port_wr[gi] = set_stb && (set_addr == 8'(BASE + 8 + gi));
  end

  // Descending scan so the lowest matching entry wins.
  always_comb begin
    hit   = 1'b0;
    hit_k = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (port_valid_q[k] && (port_num_q[k] == dst_port_q)) begin
        hit   = 1'b1;
        hit_k = 3'(k);
      end
    end
  end

  assign frame_match = ((dst_mac_q == my_mac_q) || (dst_mac_q == 48'hFFFF_FFFF_FFFF)) &&
                       (ethertype_q == 16'h0800) && (protocol_q == 8'd17) &&
                       (dst_ip_q == my_ip_q) && hit;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    dst_mac_d        = dst_mac_q;
    ethertype_d      = ethertype_q;
    protocol_d       = protocol_q;
    dst_ip_d         = dst_ip_q;
    dst_port_d       = dst_port_q;
    udp_len_d        = udp_len_q;
    ctrl_eof_d       = ctrl_eof_q;
    port_k_d         = port_k_q;
    my_mac_d         = my_mac_q;
    my_ip_d          = my_ip_q;
    port_valid_d     = port_valid_q;
    port_num_d       = port_num_q;
    frames_ok_d      = frames_ok_q;
    frames_dropped_d = frames_dropped_q;
    in_ready         = 1'b0;
    core_valid       = 1'b0;
    core_data        = in_data;

    if (set_stb && set_addr == A_MAC_HI) my_mac_d[47:32] = set_data[15:0];
    if (set_stb && set_addr == A_MAC_LO) my_mac_d[31:0]  = set_data;
    if (set_stb && set_addr == A_IP)     my_ip_d         = set_data;
    for (int k = 0; k < 8; k++) begin
      if (port_wr[k]) begin
        port_valid_d[k] = set_data[16];
        port_num_d[k]   = set_data[15:0];
      end
    end

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_data[32]) begin
          dst_mac_d[47:32] = in_data[15:0];
          if (in_data[33]) frames_dropped_d = frames_dropped_q + 16'd1;
          else begin
            idx_d   = 4'd1;
            state_d = HDR;
          end
        end
      end
      HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (idx_q)
            4'd1:    dst_mac_d[31:0] = in_data[31:0];
            4'd3:    ethertype_d     = in_data[15:0];
            4'd6:    protocol_d      = in_data[23:16];
            4'd8:    dst_ip_d        = in_data[31:0];
            4'd9:    dst_port_d      = in_data[15:0];
            4'd10:   udp_len_d       = in_data[31:16];
            default: ;
          endcase
          if (idx_q == 4'd10) begin
            idx_d      = 4'd0;
            ctrl_eof_d = in_data[33];
            port_k_d   = hit_k;
            if (frame_match) state_d = CTRL;
            else if (in_data[33]) begin
              state_d          = IDLE;
              frames_dropped_d = frames_dropped_q + 16'd1;
            end else state_d = DROP;
          end else if (in_data[33]) begin
            idx_d            = 4'd0;
            state_d          = IDLE;
            frames_dropped_d = frames_dropped_q + 16'd1;
          end else idx_d = idx_q + 4'd1;
        end
      end
      CTRL: begin
        core_valid = 1'b1;
        core_data  = {2'b00, ctrl_eof_q, 1'b1, 12'h000, port_k_q, 1'b1, udp_len_q - 16'd8};
        if (out_ready) begin
          frames_ok_d = frames_ok_q + 16'd1;
          state_d     = ctrl_eof_q ? IDLE : PAY;
        end
      end
      PAY: begin
        in_ready   = out_ready;
        core_valid = in_valid;
        core_data  = {in_data[35:33], 1'b0, in_data[31:0]};
        if (in_valid && out_ready && in_data[33]) state_d = IDLE;
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_data[33]) begin
          state_d          = IDLE;
          frames_dropped_d = frames_dropped_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    dst_mac_q   <= dst_mac_d;
    ethertype_q <= ethertype_d;
    protocol_q  <= protocol_d;
    dst_ip_q    <= dst_ip_d;
    dst_port_q  <= dst_port_d;
    udp_len_q   <= udp_len_d;
    ctrl_eof_q  <= ctrl_eof_d;
    port_k_q    <= port_k_d;
    my_mac_q    <= my_mac_d;
    my_ip_q     <= my_ip_d;
    port_num_q  <= port_num_d;
    if (reset) begin
      state_q          <= IDLE;
      idx_q            <= 4'd0;
      port_valid_q     <= 8'h00;
      frames_ok_q      <= 16'd0;
      frames_dropped_q <= 16'd0;
    end else begin
      state_q          <= clear ? IDLE : state_d;
      idx_q            <= clear ? 4'd0 : idx_d;
      port_valid_q     <= port_valid_d;
      frames_ok_q      <= frames_ok_d;
      frames_dropped_q <= frames_dropped_d;
    end
  end

  assign frames_ok      = frames_ok_q;
  assign frames_dropped = frames_dropped_q;

endmodule

// 16-deep first-word-fall-through FIFO with ready/valid on both sides.
module fifo_short (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [35:0] datain,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [35:0] dataout,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i
);

  logic [35:0] mem [16];
  logic [3:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]  count_q, count_d;
  logic        do_wr, do_rd;

  assign dst_rdy_o = (count_q != 5'd16);
  assign src_rdy_o = (count_q != 5'd0);
  assign do_wr     = src_rdy_i && dst_rdy_o;
  assign do_rd     = src_rdy_o && dst_rdy_i;
  assign dataout   = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_wr ? wr_ptr_q + 4'd1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 4'd1 : rd_ptr_q;
    count_d  = count_q + 5'(do_wr) - 5'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= datain;
    if (reset || clear) begin
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      count_q  <= 5'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_prot_eng_rx.sv
// Bench for prot_eng_rx: frame-level reference model with a per-cycle output checker.
module tb_prot_eng_rx;

  typedef logic [35:0] word_t;
  localparam int BASE_T = 64;

  logic        clk = 1'b0;
  logic        reset, clear, set_stb, src_rdy_i, dst_rdy_i, dst_rdy_o, src_rdy_o;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [35:0] datain, dataout;
  logic [15:0] frames_ok, frames_dropped;

  prot_eng_rx #(.BASE(BASE_T)) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .set_stb        (set_stb),
    .set_addr       (set_addr),
    .set_data       (set_data),
    .datain         (datain),
    .src_rdy_i      (src_rdy_i),
    .dst_rdy_o      (dst_rdy_o),
    .dataout        (dataout),
    .src_rdy_o      (src_rdy_o),
    .dst_rdy_i      (dst_rdy_i),
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  word_t       exp_q[$];
  logic [15:0] exp_ok = 16'd0, exp_drop = 16'd0;
  logic [47:0] m_mac = 48'd0;
  logic [31:0] m_ip = 32'd0;
  logic        m_valid [8];
  logic [15:0] m_port [8];
  word_t       last_ctrl = '0;
  bit          bp_en = 1'b0;
  logic        dst_hold = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else $display("ok   %s: %h", name, act);
  endtask

  // Frame-level model: decide the fate of a whole frame from its header fields.
  task automatic model_frame(input word_t f[$]);
    int eofi = -1;
    logic [47:0] dmac;
    logic [15:0] ul, dp;
    bit found = 0;
    logic [2:0] k = 3'd0;
    bit ok;
    word_t w;
    for (int i = 0; i < f.size(); i++) if (eofi < 0 && f[i][33]) eofi = i;
    if (eofi >= 0 && eofi < 10) begin
      exp_drop++;
      return;
    end
    if (f.size() < 11) return;
    dmac = {f[0][15:0], f[1][31:0]};
    dp   = f[9][15:0];
    ul   = f[10][31:16];
    for (int j = 0; j < 8; j++)
      if (!found && m_valid[j] && m_port[j] == dp) begin found = 1; k = 3'(j); end
    ok = (dmac == m_mac || dmac == 48'hFFFF_FFFF_FFFF) && f[3][15:0] == 16'h0800 &&
         f[6][23:16] == 8'd17 && f[8][31:0] == m_ip && found;
    if (ok) begin
      exp_q.push_back({2'b00, f[10][33], 1'b1, 12'h000, k, 1'b1, ul - 16'd8});
      exp_ok++;
      for (int i = 11; i < f.size(); i++) begin
        w = f[i];
        w[32] = 1'b0;
        exp_q.push_back(w);
      end
    end else if (eofi >= 0) exp_drop++;
  endtask

  task automatic build_frame(input logic [47:0] mac, input logic [15:0] et, input logic [7:0] pr,
                             input logic [31:0] ip, input logic [15:0] dport, input logic [15:0] ulen,
                             input int npay, input int trunc, input bit eof_end, output word_t f[$]);
    word_t w;
    f.delete();
    f.push_back({4'b0001, 16'h0000, mac[47:32]});
    f.push_back({4'b0000, mac[31:0]});
    f.push_back({4'b0000, 32'h0011_2233});
    f.push_back({4'b0000, 16'h4455, et});
    f.push_back({4'b0000, 16'h4500, ulen + 16'd20});
    f.push_back({4'b0000, 32'h1234_4000});
    f.push_back({4'b0000, 8'h40, pr, 16'hBEEF});
    f.push_back({4'b0000, 32'hC0A8_0A01});
    f.push_back({4'b0000, ip});
    f.push_back({4'b0000, 16'd5000, dport});
    f.push_back({4'b0000, ulen, 16'h0000});
    for (int p = 0; p < npay; p++) begin
      w = {4'b0000, dport, 16'(p * 16'h0101 + 16'h0A00)};
      if (p == 1) w[32] = 1'b1;
      if (p == npay - 1) w[35:34] = 2'b10;
      f.push_back(w);
    end
    if (trunc >= 0) while (f.size() > trunc + 1) void'(f.pop_back());
    if (eof_end) begin
      w = f[f.size() - 1];
      w[33] = 1'b1;
      f[f.size() - 1] = w;
    end
  endtask

  task automatic send_word(input word_t w);
    int  n = 0;
    bit  done = 0;
    datain    = w;
    src_rdy_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = dst_rdy_o;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 5000) begin
        vectors++;
        miscompares++;
        $display("FAIL input_stall: got dst_rdy_o=0 for %0d cycles expected acceptance", n);
        done = 1;
      end
    end
    src_rdy_i = 1'b0;
  endtask

  task automatic send_frame(input word_t f[$]);
    model_frame(f);
    foreach (f[i]) send_word(f[i]);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d words outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic wr_set(input int off, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = 8'(BASE_T + off);
    set_data = d;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
    if (off == 0) m_mac[47:32] = d[15:0];
    else if (off == 1) m_mac[31:0] = d;
    else if (off == 2) m_ip = d;
    else if (off >= 8 && off < 16) begin
      m_valid[off - 8] = d[16];
      m_port[off - 8]  = d[15:0];
    end
  endtask

  task automatic program_all();
    wr_set(0, 32'h0000_0050);
    wr_set(1, 32'hC285_3FFF);
    wr_set(2, 32'hC0A8_0A02);
    wr_set(11, {15'd0, 1'b1, 16'd49153});
    wr_set(14, {15'd0, 1'b1, 16'd49153});
    wr_set(8, {15'd0, 1'b1, 16'd1234});
    wr_set(10, {15'd0, 1'b0, 16'd7777});
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_frames_ok"}, 64'(frames_ok), 64'(exp_ok));
    chk({tag, "_frames_dropped"}, 64'(frames_dropped), 64'(exp_drop));
  endtask

  // Output checker: every accepted output word must be the next expected one.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && src_rdy_o && dst_rdy_i) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got %h expected no word", dataout);
        end else begin
          e = exp_q.pop_front();
          chk("dataout", 64'(dataout), 64'(e));
          if (dataout[32]) last_ctrl = dataout;
        end
      end
    end
  end

  initial begin
    dst_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dst_rdy_i = bp_en ? 1'($urandom_range(0, 1)) : dst_hold;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  localparam logic [47:0] MY_MAC = 48'h0050_C285_3FFF;
  localparam logic [31:0] MY_IP  = 32'hC0A8_0A02;

  initial begin
    word_t f[$];
    logic [15:0] et_t [5] = '{16'h86DD, 16'h0800, 16'h0800, 16'h0800, 16'h0800};
    logic [7:0]  pr_t [5] = '{8'd17, 8'd6, 8'd17, 8'd17, 8'd17};
    logic [31:0] ip_t [5] = '{MY_IP, MY_IP, 32'hC0A8_0A03, MY_IP, MY_IP};
    logic [47:0] mac_t [5] = '{MY_MAC, MY_MAC, MY_MAC, 48'h0050_C285_3FFE, MY_MAC};
    logic [15:0] pt_t [5] = '{16'd49153, 16'd49153, 16'd49153, 16'd49153, 16'd7777};
    for (int j = 0; j < 8; j++) begin m_valid[j] = 1'b0; m_port[j] = 16'd0; end
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    src_rdy_i = 1'b0; datain = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_src_rdy_o", 64'(src_rdy_o), 64'd0);
    chk("rst_dst_rdy_o", 64'(dst_rdy_o), 64'd1);
    chk("rst_frames_ok", 64'(frames_ok), 64'd0);
    chk("rst_frames_dropped", 64'(frames_dropped), 64'd0);
    @(posedge clk); #1;
    program_all();

    // Matching frame, entry 3 (lowest of 3 and 6)
    build_frame(MY_MAC, 16'h0800, 8'd17, MY_IP, 16'd49153, 16'd24, 4, -1, 1, f);
    send_frame(f);
    drain();
    chk("t1_ctrl_word", 64'(last_ctrl), 64'h1_0007_0010);
    chk("t1_frames_ok", 64'(frames_ok), 64'd1);
    check_counters("t1");

    // Junk, broadcast with wrong port, then matching broadcast frame
    for (int j = 0; j < 3; j++) send_word({4'b0000, 32'hDEAD_0000 + 32'(j)});
    build_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 8'd17, MY_IP, 16'd50000, 16'd16, 2, -1, 1, f);
    send_frame(f);
    build_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 8'd17, MY_IP, 16'd49153, 16'd20, 3, -1, 1, f);
    send_frame(f);
    drain();
    chk("t2_frames_dropped", 64'(frames_dropped), 64'd1);
    check_counters("t2");

    // Truncated at w6, then a good frame
    build_frame(MY_MAC, 16'h0800, 8'd17, MY_IP, 16'd49153, 16'd24, 4, 6, 1, f);
    send_frame(f);
    build_frame(MY_MAC, 16'h0800, 8'd17, MY_IP, 16'd49153, 16'd12, 1, -1, 1, f);
    send_frame(f);
    drain();
    check_counters("t3");

    // Zero-payload frame, eof on w10
    build_frame(MY_MAC, 16'h0800, 8'd17, MY_IP, 16'd49153, 16'd8, 0, -1, 1, f);
    send_frame(f);
    drain();
    chk("t4_ctrl_word", 64'(last_ctrl), 64'h3_0007_0000);
    check_counters("t4");

    // Individual mismatches, then entry 0 match
    for (int j = 0; j < 5; j++) begin
      build_frame(mac_t[j], et_t[j], pr_t[j], ip_t[j], pt_t[j], 16'd12, 1, -1, 1, f);
      send_frame(f);
    end
    build_frame(MY_MAC, 16'h0800, 8'd17, MY_IP, 16'd1234, 16'd16, 2, -1, 1, f);
    send_frame(f);
    drain();
    chk("t5_ctrl_word", 64'(last_ctrl), 64'h1_0001_0008);
    check_counters("t5");

    // Random backpressure over a long frame
    bp_en = 1'b1;
    build_frame(MY_MAC, 16'h0800, 8'd17, MY_IP, 16'd49153, 16'd264, 64, -1, 1, f);
    send_frame(f);
    drain();
    bp_en = 1'b0;
    check_counters("t6");

    // Reset in the middle of payload with output held
    dst_hold = 1'b0;
    @(posedge clk); #1;
    build_frame(MY_MAC, 16'h0800, 8'd17, MY_IP, 16'd49153, 16'd48, 5, -1, 0, f);
    send_frame(f);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t7_src_rdy_before_reset", 64'(src_rdy_o), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_ok = 16'd0;
    exp_drop = 16'd0;
    for (int j = 0; j < 8; j++) m_valid[j] = 1'b0;
    chk("t7_src_rdy_after_reset", 64'(src_rdy_o), 64'd0);
    check_counters("t7");
    dst_hold = 1'b1;
    program_all();
    build_frame(MY_MAC, 16'h0800, 8'd17, MY_IP, 16'd49153, 16'd16, 2, -1, 1, f);
    send_frame(f);
    drain();
    chk("t8_frames_ok", 64'(frames_ok), 64'd1);
    check_counters("t8");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
